// File: rtl/alu_fp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_fp_pkg : opcodes, FSM states and sizing helper for alu_fp_seq   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package alu_fp_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w = w + 1;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_fp_iter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_fp_iter : shared shift-add multiplier / restoring divider core |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module alu_fp_iter
  import alu_fp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             load_div,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_next,
  output logic             ovf_next
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = clog2(N + 1);

  logic             mode_div;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [N-1:0]     sh;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH-1:0]   acc_next;
  logic [N-1:0]       sh_next;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_shr;
  logic               divisor_zero;

  assign divisor_zero = (opnd == '0);

  // MUL: acc:sh[W-1:0] is the product, multiplier bits shift out of sh[0].
  // DIV: sh holds dividend bits shifting into the remainder, quotient bits shifting in.
  always_comb begin
    mul_sum   = {1'b0, acc} + (sh[0] ? {1'b0, opnd} : '0);
    div_shift = {acc, sh[N-1]};
    div_diff  = div_shift - {1'b0, opnd};
    acc_next  = acc;
    sh_next   = sh;
    if (mode_div) begin
      acc_next = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      sh_next  = {sh[N-2:0], ~div_diff[WIDTH]};
    end else begin
      acc_next             = mul_sum[WIDTH:1];
      sh_next[WIDTH-1:0]   = {mul_sum[0], sh[WIDTH-1:1]};
    end
    prod_shr = {acc_next, sh_next[WIDTH-1:0]} >> FRAC;
    if (mode_div) begin
      res_next = divisor_zero ? '1 : sh_next[WIDTH-1:0];
      ovf_next = divisor_zero | (|(sh_next >> WIDTH));
    end else begin
      res_next = prod_shr[WIDTH-1:0];
      ovf_next = |(prod_shr >> WIDTH);
    end
  end

  assign last = (mode_div & divisor_zero) | (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_div <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      sh       <= '0;
      opnd     <= '0;
    end else if (load) begin
      mode_div <= load_div;
      cnt      <= load_div ? CW'(N) : CW'(WIDTH);
      acc      <= '0;
      sh       <= load_div ? (N'(a) << FRAC) : N'(b);
      opnd     <= load_div ? b : a;
    end else if (step) begin
      acc <= acc_next;
      sh  <= sh_next;
      cnt <= cnt - CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_fp_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_fp_seq : sequential fixed-point ADD/SUB/MUL/DIV with handshake |
// | ALU_FP_SAT_EN clamps results on overflow.           rev 1.0        |
// +--------------------------------------------------------------------+
module alu_fp_seq
  import alu_fp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  state_t           state, state_next;
  logic             load, step, fin;
  logic [WIDTH-1:0] fin_r, fin_val;
  logic             fin_ovf;
  logic [WIDTH:0]   add_sum, sub_diff;
  logic             iter_last, iter_ovf;
  logic [WIDTH-1:0] iter_res;

  alu_fp_iter #(.WIDTH(WIDTH), .FRAC(FRAC)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_div (opcode == OP_DIV),
    .step     (step),
    .a        (a),
    .b        (b),
    .last     (iter_last),
    .res_next (iter_res),
    .ovf_next (iter_ovf)
  );

  always_comb begin
    add_sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    sub_diff   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    fin        = 1'b0;
    fin_r      = iter_res;
    fin_ovf    = iter_ovf;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (opcode)
            OP_ADD: begin
              fin     = 1'b1;
              fin_r   = add_sum[WIDTH-1:0];
              fin_ovf = add_sum[WIDTH];
            end
            OP_SUB: begin
              fin     = 1'b1;
              fin_r   = sub_diff[WIDTH-1:0];
              fin_ovf = sub_diff[WIDTH];
            end
            default: begin
              load       = 1'b1;
              state_next = (opcode == OP_DIV) ? ST_DIV : ST_MUL;
            end
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        step = 1'b1;
        if (iter_last) begin
          fin        = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef ALU_FP_SAT_EN
  // A SUB can only finish from IDLE, and it underflows toward zero.
  always_comb begin
    if (!fin_ovf)
      fin_val = fin_r;
    else if (state == ST_IDLE && opcode == OP_SUB)
      fin_val = '0;
    else
      fin_val = '1;
  end
`else
  assign fin_val = fin_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      result <= '0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_next;
      done  <= fin;
      if (fin) begin
        result <= fin_val;
        ovf    <= fin_ovf;
        zero   <= (fin_val == '0);
      end
    end
  end

  assign cout = ovf;
  assign busy = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_fp_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_fp_seq : scoreboard bench for alu_fp_seq (WIDTH=8, FRAC=4)  |
// | Honours ALU_FP_SAT_EN in its reference model.       rev 1.0        |
// +--------------------------------------------------------------------+
module tb_alu_fp_seq;
  import alu_fp_pkg::*;

  localparam int W = 8;
  localparam int F = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   opcode = 2'b00;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic [W-1:0] result;
  logic         cout, ovf, zero, busy, done;

  alu_fp_seq #(.WIDTH(W), .FRAC(F)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .a(a), .b(b), .cin(cin),
    .result(result), .cout(cout), .ovf(ovf), .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         ovf;
    logic         zero;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] xa, xb, input logic xc);
    exp_t   e;
    longint s;
    case (op)
      OP_ADD: begin
        s = longint'(xa) + longint'(xb) + longint'(xc);
        e.r = W'(s); e.ovf = (s > 255); e.lat = 1;
      end
      OP_SUB: begin
        s = longint'(xa) - longint'(xb) - longint'(xc);
        e.r = W'(s); e.ovf = (s < 0); e.lat = 1;
      end
      OP_MUL: begin
        s = longint'(xa) * longint'(xb);
        e.r = W'(s >> F); e.ovf = ((s >> (W + F)) != 0); e.lat = W + 1;
      end
      default: begin
        if (xb == 0) begin
          e.r = '1; e.ovf = 1'b1; e.lat = 2;
        end else begin
          s = (longint'(xa) << F) / longint'(xb);
          e.r = W'(s); e.ovf = ((s >> W) != 0); e.lat = W + F + 1;
        end
      end
    endcase
`ifdef ALU_FP_SAT_EN
    if (e.ovf) e.r = (op == OP_SUB) ? '0 : '1;
`endif
    e.zero = (e.r == '0);
    return e;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [W-1:0] xa, xb, input logic xc);
    @(negedge clk);
    opcode = op; a = xa; b = xb; cin = xc; start = 1'b1;
    sb.push_back(model(op, xa, xb, xc));
  endtask

  // Cycles from acceptance to the done pulse; -1 if it never came.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({result, cout, ovf, zero, busy, done} !== {{W{1'b0}}, 5'b0})
      $display("FAIL reset_hold: got result=%h cout=%b ovf=%b zero=%b busy=%b done=%b, expected all 0",
               result, cout, ovf, zero, busy, done);
    if ({result, cout, ovf, zero, busy, done} !== {{W{1'b0}}, 5'b0}) n_fail++;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({result, busy, done} !== {{W{1'b0}}, 2'b0}) begin
      n_fail++;
      $display("FAIL reset_idle: got result=%h busy=%b done=%b, expected 0", result, busy, done);
    end
  endtask

  task automatic test_addsub();
    logic [W-1:0] va[6] = '{8'h78, 8'h78, 8'h78, 8'h10, 8'hFF, 8'h00};
    logic [W-1:0] vb[6] = '{8'h24, 8'h24, 8'h24, 8'h20, 8'h01, 8'h00};
    logic [1:0]   vo[6] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_ADD, OP_SUB};
    logic         vc[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_t e;
    int   cyc;
    for (int i = 0; i < 6; i++) begin
      issue(vo[i], va[i], vb[i], vc[i]);
      wait_done(cyc);
      e = sb.pop_front();
      n_tests++;
      if (cyc !== e.lat || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL addsub_latency[%0d]: got %0d busy=%b, expected %0d busy=0", i, cyc, busy, e.lat);
      end
      n_tests++;
      if ({result, ovf, cout, zero} !== {e.r, e.ovf, e.ovf, e.zero}) begin
        n_fail++;
        $display("FAIL addsub_result[%0d]: got %h ovf=%b cout=%b zero=%b, expected %h ovf=%b zero=%b",
                 i, result, ovf, cout, zero, e.r, e.ovf, e.zero);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        n_tests++;
        if ({done, result, ovf, zero} !== {1'b1, e.r, e.ovf, e.zero}) begin
          n_fail++;
          $display("FAIL b2b[%0d]: got done=%b %h ovf=%b zero=%b, expected done=1 %h ovf=%b zero=%b",
                   i, done, result, ovf, zero, e.r, e.ovf, e.zero);
        end
      end
      if (i < 6) begin
        opcode = (i % 2 == 0) ? OP_ADD : OP_SUB;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        start = 1'b1;
        sb.push_back(model(opcode, a, b, cin));
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_mul();
    exp_t e;
    int   cyc;
    issue(OP_MUL, 8'h18, 8'h20, 1'b0);
    for (int c = 1; c <= W + 1; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 3) begin
        start = 1'b1; opcode = OP_ADD; a = 8'hFF; b = 8'h01;
      end
      n_tests++;
      if ({busy, done} !== {1'(c <= W), 1'(c == W + 1)}) begin
        n_fail++;
        $display("FAIL mul_timing[c%0d]: got busy=%b done=%b, expected busy=%b done=%b",
                 c, busy, done, c <= W, c == W + 1);
      end
    end
    e = sb.pop_front();
    n_tests++;
    if ({result, ovf, zero} !== {e.r, e.ovf, e.zero}) begin
      n_fail++;
      $display("FAIL mul_basic: got %h ovf=%b zero=%b, expected %h ovf=%b zero=%b",
               result, ovf, zero, e.r, e.ovf, e.zero);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_ignored_start: got done=%b, expected 0", done);
    end
    issue(OP_MUL, 8'h78, 8'h24, 1'b1);
    wait_done(cyc);
    e = sb.pop_front();
    n_tests++;
    if ({cyc, result, ovf, cout} !== {e.lat, e.r, e.ovf, e.ovf}) begin
      n_fail++;
      $display("FAIL mul_ovf: got lat=%0d %h ovf=%b cout=%b, expected lat=%0d %h ovf=%b",
               cyc, result, ovf, cout, e.lat, e.r, e.ovf);
    end
  endtask

  task automatic test_div();
    logic [W-1:0] va[4] = '{8'h78, 8'h10, 8'hFF, 8'h01};
    logic [W-1:0] vb[4] = '{8'h24, 8'h00, 8'h01, 8'hFF};
    exp_t e;
    int   cyc;
    for (int i = 0; i < 4; i++) begin
      issue(OP_DIV, va[i], vb[i], 1'b0);
      wait_done(cyc);
      e = sb.pop_front();
      n_tests++;
      if (cyc !== e.lat) begin
        n_fail++;
        $display("FAIL div_latency[%0d]: got %0d, expected %0d", i, cyc, e.lat);
      end
      n_tests++;
      if ({result, ovf, cout, zero} !== {e.r, e.ovf, e.ovf, e.zero}) begin
        n_fail++;
        $display("FAIL div_result[%0d]: got %h ovf=%b cout=%b zero=%b, expected %h ovf=%b zero=%b",
                 i, result, ovf, cout, zero, e.r, e.ovf, e.zero);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   cyc;
    bit   stray;
    issue(OP_ADD, 8'h78, 8'h24, 1'b1);
    wait_done(cyc);
    e = sb.pop_front();
    n_tests++;
    if (result !== e.r) begin
      n_fail++;
      $display("FAIL pre_abort_add: got %h, expected %h", result, e.r);
    end
    issue(OP_MUL, 8'h78, 8'h24, 1'b0);
    void'(sb.pop_back());
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 4) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({result, cout, ovf, zero, busy, done} !== {{W{1'b0}}, 5'b0}) begin
      n_fail++;
      $display("FAIL abort_state: got result=%h cout=%b ovf=%b zero=%b busy=%b done=%b, expected all 0",
               result, cout, ovf, zero, busy, done);
    end
    issue(OP_ADD, 8'h11, 8'h22, 1'b0);
    wait_done(cyc);
    e = sb.pop_front();
    n_tests++;
    if ({cyc, result, ovf, zero} !== {e.lat, e.r, e.ovf, e.zero}) begin
      n_fail++;
      $display("FAIL post_abort_add: got lat=%0d %h ovf=%b zero=%b, expected lat=%0d %h ovf=%b zero=%b",
               cyc, result, ovf, zero, e.lat, e.r, e.ovf, e.zero);
    end
    stray = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    n_tests++;
    if (stray) begin
      n_fail++;
      $display("FAIL abort_no_done: got a done/busy after abort, expected none");
    end
  endtask

  task automatic test_random();
    exp_t e;
    int   cyc;
    logic [1:0] op;
    for (int i = 0; i < 16; i++) begin
      op = 2'($urandom_range(0, 3));
      issue(op, W'($urandom), (i == 5) ? '0 : W'($urandom), 1'($urandom));
      wait_done(cyc);
      e = sb.pop_front();
      n_tests++;
      if ({cyc, result, ovf, cout, zero} !== {e.lat, e.r, e.ovf, e.ovf, e.zero}) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d: got lat=%0d %h ovf=%b cout=%b zero=%b, expected lat=%0d %h ovf=%b zero=%b",
                 i, op, cyc, result, ovf, cout, zero, e.lat, e.r, e.ovf, e.zero);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_back_to_back();
    test_mul();
    test_div();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/alu_fp_seq.md
# alu_fp_seq

Parametrised, sequential successor to the team's 8-bit combinational fixed-point add/sub ALU.
- Operates on unsigned Q(WIDTH-FRAC).FRAC operands.
- Adds single-cycle ADD/SUB plus iterative multiply (shift-add) and divide (restoring) behind a start/busy/done handshake.
- Registers all outputs and raises carry/overflow/zero flags.
- Sits between the register file and the writeback mux in the datapath.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥4)
- FRAC, 4, fractional bits (0 ≤ FRAC < WIDTH)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; accepted only when busy=0
- opcode  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry/borrow in (ADD/SUB only; ignored for MUL/DIV)
- result  out  WIDTH  registered result, held until next done
- cout  out  1  carry out (ADD), borrow (SUB), equals ovf (MUL/DIV)
- ovf  out  1  result not representable in WIDTH bits
- zero  out  1  result == 0
- busy  out  1  iterative op in progress
- done  out  1  one-cycle pulse, result/flags valid

## Operation
- Reset: result=0, cout=0, ovf=0, zero=0, busy=0, done=0, state IDLE, iteration counter 0. A reset mid-operation aborts the operation with no done pulse.
- States: IDLE, MUL, DIV.
- IDLE & start & ADD/SUB: compute, register outputs, pulse done next cycle; stay IDLE.
- IDLE & start & MUL/DIV: latch a, b, opcode, go to MUL/DIV, load the counter.
- start while busy=1 is ignored; operands are not re-sampled.
- ADD: {cout,r} = a+b+cin in WIDTH+1 bits; ovf=cout.
- SUB: {borrow,r} = a-b-cin in WIDTH+1 bits; cout=ovf=borrow (1 when a < b+cin).
- MUL: p = a*b, 2·WIDTH bits, WIDTH iterations of shift-add.
  - r = p[FRAC +: WIDTH], truncating.
  - ovf = |p[2·WIDTH-1 : WIDTH+FRAC].
- DIV: q = (a<<FRAC)/b, WIDTH+FRAC restoring iterations.
  - r = q[WIDTH-1:0]; ovf = |q[WIDTH+FRAC-1:WIDTH].
  - b==0: skip iterations, r = all ones, ovf=1, done after 1 cycle of DIV state.
- zero is computed on the final r (after saturation, if enabled).
- Final cycle of MUL/DIV: register outputs, pulse done, return to IDLE.

## Timing
- Start accepted in cycle 0.
- Latency:
  - ADD/SUB: done and result in cycle 1; busy stays 0, so back-to-back starts every cycle are allowed.
  - MUL: busy=1 in cycles 1..WIDTH; done in cycle WIDTH+1 with busy=0.
  - DIV: busy=1 in cycles 1..WIDTH+FRAC; done in cycle WIDTH+FRAC+1. With b==0, done in cycle 2.
- start in the done cycle is accepted (busy=0).
- result/flags change only in a done cycle or on reset.

## Configuration
- ALU_FP_SAT_EN defined: on ovf, result clamps.
  - ADD/MUL/DIV clamp to all ones.
  - SUB clamps to 0.
  - cout and ovf are still reported.
- Undefined: results wrap/truncate as in Operation; no clamp logic is synthesised.

## Structure
- Package alu_fp_pkg holds:
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV
  - state encoding ST_IDLE/ST_MUL/ST_DIV
  - counter-width function clog2(WIDTH+FRAC+1)
- One sub-module, alu_fp_iter: shared shift register, partial remainder/product and iteration counter for MUL and DIV.
- Top level holds the FSM, ADD/SUB, saturation and output registers.

## Test plan
All scenarios use WIDTH=8, FRAC=4.
- ADD a=0x78, b=0x24, cin=0 -> cycle 1: done, result=0x9C, cout=0, ovf=0; cin=1 -> 0x9D.
- SUB a=0x78, b=0x24 -> 0x54, cout=0. SUB a=0x10, b=0x20 -> 0xF0, cout=ovf=1 (0x00 with SAT_EN).
- MUL a=0x18, b=0x20 (1.5·2.0):
  - busy cycles 1–8; done cycle 9; result=0x30, ovf=0.
  - start re-pulsed in cycle 3 with other operands is ignored.
- MUL a=0x78, b=0x24 -> result=0x0E, ovf=cout=1 (0xFF with SAT_EN).
- DIV a=0x78, b=0x24 -> done cycle 13, result=0x35. DIV a=0x10, b=0x00 -> done cycle 2, result=0xFF, ovf=1.
- rst asserted in cycle 4 of MUL -> next cycle:
  - all outputs 0, busy=0, no done pulse.
  - A new ADD start the following cycle completes normally.
